// File: rtl/sync_fifo.sv
// Single-clock FIFO with DEPTH x DATA_WIDTH storage, registered read data and
// count-based full/empty flags. Reset is asynchronous and active-low.
module sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
) (
    input  logic [DATA_WIDTH-1:0] go_data,
    input  logic                  reset,
    input  logic                  write,
    input  logic                  read,
    input  logic                  clk,
    output logic                  full,
    output logic                  empty,
    output logic [DATA_WIDTH-1:0] get_data
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ZERO   = '0;
    localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]         wr_ptr_r;
    logic [AW-1:0]         rd_ptr_r;
    logic [AW:0]           count_r;
    logic [DATA_WIDTH-1:0] get_data_r;
    logic                  full_s;
    logic                  empty_s;
    logic                  wr_en_s;
    logic                  rd_en_s;

    // Flag decode and accept qualification; a read frees a slot on the same
    // edge, so a write while full is accepted only alongside a read.
    always_comb begin
        full_s  = (count_r == FULL_COUNT);
        empty_s = (count_r == CNT_ZERO);
        rd_en_s = read & ~empty_s;
        wr_en_s = write & (~full_s | read);
    end

    // Storage array: no reset, contents are only observed after being written.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= go_data;
        end
    end

    // Pointers, occupancy count and registered read data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            get_data_r <= '0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (rd_en_s) begin
                rd_ptr_r   <= rd_ptr_r + PTR_ONE;
                get_data_r <= mem_r[rd_ptr_r];
            end
            case ({wr_en_s, rd_en_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    assign full     = full_s;
    assign empty    = empty_s;
    assign get_data = get_data_r;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo: fill/drain, overflow, underflow,
// simultaneous access and asynchronous reset.
module tb_sync_fifo;

    logic [7:0] go_data;
    logic       reset;
    logic       write;
    logic       read;
    logic       clk;
    logic       full;
    logic       empty;
    logic [7:0] get_data;

    int n_vec_s;
    int n_err_s;

    sync_fifo #(.DATA_WIDTH(8), .DEPTH(8)) dut (
        .go_data  (go_data),
        .reset    (reset),
        .write    (write),
        .read     (read),
        .clk      (clk),
        .full     (full),
        .empty    (empty),
        .get_data (get_data)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec_s++;
        if (obs !== exp) begin
            n_err_s++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        write = 1'b1; read = 1'b0; go_data = d;
        tick();
        write = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        read = 1'b1; write = 1'b0;
        tick();
        read = 1'b0;
        check_vec(tag, 32'(get_data), 32'(exp));
    endtask

    logic [7:0] fill_vec [6];

    initial begin
        n_vec_s = 0;
        n_err_s = 0;
        fill_vec[0] = 8'h40; fill_vec[1] = 8'h20; fill_vec[2] = 8'h00;
        fill_vec[3] = 8'h06; fill_vec[4] = 8'h1A; fill_vec[5] = 8'h01;
        reset = 1'b0; write = 1'b0; read = 1'b0; go_data = 8'h00;
        #12;
        check_vec("rst_empty", 32'(empty), 32'd1);
        check_vec("rst_full", 32'(full), 32'd0);
        check_vec("rst_data", 32'(get_data), 32'd0);

        // Reset then fill; the first edge after release must be honoured.
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            push(fill_vec[i]);
            check_vec("fill_empty", 32'(empty), 32'd0);
        end
        check_vec("fill6_full", 32'(full), 32'd0);

        // Drain in order.
        for (int i = 0; i < 6; i++) begin
            pop_check("drain_data", fill_vec[i]);
        end
        check_vec("drain_empty", 32'(empty), 32'd1);

        // Underflow: nothing moves and data holds.
        pop_check("uflow_hold", 8'h01);
        check_vec("uflow_empty", 32'(empty), 32'd1);
        push(8'hAA);
        pop_check("uflow_ptr", 8'hAA);

        // Fill to full, overflow attempt, then drain.
        for (int i = 1; i <= 8; i++) begin
            check_vec("pre_full", 32'(full), 32'd0);
            push(8'(i));
        end
        check_vec("full_set", 32'(full), 32'd1);
        push(8'hFF);
        check_vec("oflow_full", 32'(full), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            pop_check("oflow_data", 8'(i));
        end
        check_vec("oflow_empty", 32'(empty), 32'd1);

        // Simultaneous access at count=3 keeps the count and order.
        push(8'h11); push(8'h22); push(8'h33);
        for (int i = 0; i < 4; i++) begin
            write = 1'b1; read = 1'b1; go_data = 8'(8'h44 + 8'(i) * 8'h11);
            tick();
            check_vec("rw_data", 32'(get_data), 32'(8'h11 + 8'(i) * 8'h11));
        end
        write = 1'b0; read = 1'b0;
        check_vec("rw_empty", 32'(empty), 32'd0);
        check_vec("rw_full", 32'(full), 32'd0);
        pop_check("rw_tail0", 8'h55);
        pop_check("rw_tail1", 8'h66);
        pop_check("rw_tail2", 8'h77);
        check_vec("rw_cnt3", 32'(empty), 32'd1);

        // Simultaneous access while empty: only the write is taken.
        write = 1'b1; read = 1'b1; go_data = 8'h99;
        tick();
        write = 1'b0; read = 1'b0;
        check_vec("rwe_empty", 32'(empty), 32'd0);
        check_vec("rwe_hold", 32'(get_data), 32'h77);
        pop_check("rwe_data", 8'h99);
        check_vec("rwe_drain", 32'(empty), 32'd1);

        // Simultaneous access while full: both taken, oldest word returned.
        for (int i = 0; i < 8; i++) begin
            push(8'(8'hA0 + 8'(i)));
        end
        check_vec("rwf_pre", 32'(full), 32'd1);
        write = 1'b1; read = 1'b1; go_data = 8'hB0;
        tick();
        write = 1'b0; read = 1'b0;
        check_vec("rwf_data", 32'(get_data), 32'hA0);
        check_vec("rwf_full", 32'(full), 32'd1);
        for (int i = 1; i < 8; i++) begin
            pop_check("rwf_drain", 8'(8'hA0 + 8'(i)));
        end
        pop_check("rwf_last", 8'hB0);
        check_vec("rwf_empty", 32'(empty), 32'd1);

        // Asynchronous reset mid-stream with five entries held.
        for (int i = 0; i < 5; i++) begin
            push(8'(8'hC0 + 8'(i)));
        end
        #2;
        reset = 1'b0;
        #1;
        check_vec("arst_empty", 32'(empty), 32'd1);
        check_vec("arst_full", 32'(full), 32'd0);
        check_vec("arst_data", 32'(get_data), 32'd0);
        tick();
        reset = 1'b1;
        pop_check("arst_uflow", 8'h00);
        check_vec("arst_after", 32'(empty), 32'd1);
        push(8'h5A);
        pop_check("arst_first", 8'h5A);
        check_vec("arst_final", 32'(empty), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec_s, n_err_s);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; the clock port is named clk and the reset port is named reset.
REQ-002 Parameter DATA_WIDTH, default 8, SHALL set the data word width.
REQ-003 Parameter DEPTH, default 8, SHALL set the number of storage entries (power of two, >=2).
REQ-004 Port clk  input  1  SHALL be the clock; all state updates occur on its rising edge.
REQ-005 Port reset  input  1  SHALL be the asynchronous active-low reset (0 = reset).
REQ-006 Port go_data  input  DATA_WIDTH  SHALL carry the write data.
REQ-007 Port write  input  1  SHALL be the write request.
REQ-008 Port read  input  1  SHALL be the read request.
REQ-009 Port full  output  1  SHALL assert when DEPTH entries are stored.
REQ-010 Port empty  output  1  SHALL assert when zero entries are stored.
REQ-011 Port get_data  output  DATA_WIDTH  SHALL carry the registered read data.
REQ-012 Ports SHALL be declared in positional order go_data, reset, write, read, clk, full, empty, get_data.

Function
REQ-013 Storage SHALL be a DEPTH x DATA_WIDTH array with a write pointer, a read pointer (log2(DEPTH) bits each) and an occupancy count (log2(DEPTH)+1 bits).
REQ-014 A write SHALL be accepted on a rising edge when write=1 and full=0: go_data is stored at the write pointer, and the write pointer increments.
REQ-015 A read SHALL be accepted on a rising edge when read=1 and empty=0: the entry at the read pointer is loaded into get_data, and the read pointer increments.
REQ-016 Read latency SHALL be one cycle: get_data shows the word on the edge that accepts the read and holds it until the next accepted read.
REQ-017 Pointers SHALL wrap from DEPTH-1 to 0 with no gap or bubble.
REQ-018 A write while full SHALL be ignored: no storage, pointer or count change, and no error flag.
REQ-019 A read while empty SHALL be ignored, and get_data SHALL hold its previous value.
REQ-020 Simultaneous write and read with 0<count<DEPTH SHALL both be accepted, and count SHALL be unchanged.
REQ-021 Simultaneous write and read when empty SHALL accept only the write, so count becomes 1.
REQ-022 Simultaneous write and read when full SHALL accept both (the read frees a slot in the same edge), so count stays DEPTH and data order is preserved.
REQ-023 Count SHALL increment on a write-only accept, decrement on a read-only accept, and otherwise hold.
REQ-024 full SHALL equal (count==DEPTH) and empty SHALL equal (count==0), decoded combinationally from registered count.
REQ-025 Data SHALL be returned strictly first-in-first-out, and the block SHALL not alter it.

Reset
REQ-026 While reset=0, the pointers and count SHALL clear to 0 and get_data SHALL clear to 0 immediately, independent of clk.
REQ-027 During reset, full SHALL be 0 and empty SHALL be 1.
REQ-028 Storage array contents SHALL not require reset and are unobservable until rewritten.
REQ-029 Reset asserted mid-operation SHALL discard all stored entries, and after release the FIFO SHALL behave as empty.
REQ-030 Requests on the first edge after reset release SHALL be honoured normally.

Verification
REQ-031 Reset then fill: hold reset=0, release, write 0x40,0x20,0x00,0x06,0x1A,0x01 on consecutive edges -> empty deasserts after the first edge, and full=0 with count=6.
REQ-032 Drain: read six times -> get_data sequence 0x40,0x20,0x00,0x06,0x1A,0x01 (one per edge), and empty=1 after the sixth read with get_data holding 0x01.
REQ-033 Full and overflow: write 8 words 0x01..0x08 -> full=1 after the 8th; a 9th write of 0xFF is ignored, and eight reads return 0x01..0x08.
REQ-034 Underflow: read on an empty FIFO -> get_data unchanged, empty stays 1, and pointers do not move.
REQ-035 Simultaneous access: with count=3, assert write+read for 4 edges -> count stays 3 and outputs stay in FIFO order; with write+read while empty, only the write is taken; with write+read while full, full stays 1 and get_data returns the oldest word.
REQ-036 Async reset mid-stream: with count=5, pull reset low between edges -> empty=1, full=0 and get_data=0 immediately, without a clock edge.
